expr_result_unpacker: RTL and testbench

//   Reader side of the 90-bit packed expression-result bus {y0,...,y17}.

---
 rtl/expr_result_unpacker_if.sv | 26 ++
 rtl/expr_result_unpacker.sv | 92 +++++++++
 tb/tb_expr_result_unpacker.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/expr_result_unpacker_if.sv
// Handshake bundle for the expression-result unpacker: packed word in, fields out.
interface expr_result_unpacker_if #(
    parameter int unsigned OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [89:0]      in_word;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_idx;
    logic [OUT_W-1:0] out_data;
    logic             out_signed;
    logic             out_last;

    // Producer of packed words and consumer of fields
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_idx, out_data, out_signed, out_last
    );

    // The unpacker itself
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_idx, out_data, out_signed, out_last
    );
endinterface

// File: rtl/expr_result_unpacker.sv
// Streams the 18 fields of a 90-bit packed expression result, y0 first, one per
// accepted cycle. Field widths cycle 4,5,6; groups 1, 3 and 5 (of three) are signed.
module expr_result_unpacker #(
    parameter int unsigned OUT_W = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    expr_result_unpacker_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [89:0] sr_q, sr_d;

    logic [2:0]       fld_w;
    logic             fld_signed;
    logic             fld_last;
    logic [OUT_W-1:0] fld_ext;

    // Field geometry decoded from the current index
    always_comb begin
        fld_w      = 3'd4 + 3'(idx_q % 5'd3);
        fld_signed = idx_q inside {[5'd3:5'd5], [5'd9:5'd11], [5'd15:5'd17]};
        fld_last   = (idx_q == 5'd17);
    end

    // Extract the current field from the top of sr and widen it
    always_comb begin
        fld_ext = '0;
        case (fld_w)
            3'd4: fld_ext = fld_signed ? {{(OUT_W-4){sr_q[89]}}, sr_q[89:86]}
                                       : {{(OUT_W-4){1'b0}}, sr_q[89:86]};
            3'd5: fld_ext = fld_signed ? {{(OUT_W-5){sr_q[89]}}, sr_q[89:85]}
                                       : {{(OUT_W-5){1'b0}}, sr_q[89:85]};
            default: fld_ext = fld_signed ? {{(OUT_W-6){sr_q[89]}}, sr_q[89:84]}
                                          : {{(OUT_W-6){1'b0}}, sr_q[89:84]};
        endcase
    end

    // Handshake and field outputs; a new word may land on the last field's edge
    always_comb begin
        bus.out_valid  = (state_q == EMIT);
        bus.in_ready   = (state_q == IDLE) || ((state_q == EMIT) && fld_last && bus.out_ready);
        bus.out_idx    = idx_q;
        bus.out_data   = fld_ext;
        bus.out_signed = fld_signed;
        bus.out_last   = fld_last;
    end

    // Next-state: load on input accept, shift out one field per output accept
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        if (state_q == IDLE) begin
            if (bus.in_valid) begin
                state_d = EMIT;
                idx_d   = 5'd0;
                sr_d    = bus.in_word;
            end
        end else if (bus.out_ready) begin
            if (fld_last) begin
                if (bus.in_valid) begin
                    idx_d = 5'd0;
                    sr_d  = bus.in_word;
                end else begin
                    state_d = IDLE;
                    idx_d   = 5'd0;
                    sr_d    = sr_q << fld_w;
                end
            end else begin
                idx_d = idx_q + 5'd1;
                sr_d  = sr_q << fld_w;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end
endmodule

// File: tb/tb_expr_result_unpacker.sv
// Scoreboard bench: stimulus pushes expected fields, a negedge monitor pops and compares.
module tb_expr_result_unpacker;
    localparam int unsigned OUT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    expr_result_unpacker_if #(.OUT_W(OUT_W)) bus ();

    expr_result_unpacker #(.OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
        logic       sgn;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int fwid(int k);
        return 4 + (k % 3);
    endfunction

    function automatic int fstart(int k);
        return 89 - (k / 3) * 15 - (((k % 3) == 0) ? 0 : (((k % 3) == 1) ? 4 : 9));
    endfunction

    function automatic logic fsgn(int k);
        return ((k / 3) % 2) == 1;
    endfunction

    function automatic logic [89:0] put_field(logic [89:0] w, int k, logic [5:0] v);
        logic [89:0] r = w;
        for (int i = 0; i < fwid(k); i++) r[fstart(k) - i] = v[fwid(k) - 1 - i];
        return r;
    endfunction

    function automatic logic [7:0] model_field(logic [89:0] w, int k);
        logic [5:0] v = '0;
        logic [7:0] r;
        for (int i = 0; i < fwid(k); i++) v[fwid(k) - 1 - i] = w[fstart(k) - i];
        r = {2'b00, v};
        if (fsgn(k) && v[fwid(k) - 1]) r = r | (8'hFF << fwid(k));
        return r;
    endfunction

    task automatic push_exp(int k, logic [7:0] d);
        exp_t e;
        e.idx  = 5'(k);
        e.data = d;
        e.sgn  = fsgn(k);
        e.last = (k == 17);
        q.push_back(e);
    endtask

    task automatic push_model(logic [89:0] w);
        for (int k = 0; k < 18; k++) push_exp(k, model_field(w, k));
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted field must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_field: got idx %0d with empty queue", bus.out_idx);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({bus.out_idx, bus.out_data, bus.out_signed, bus.out_last} !== e) begin
                    errors++;
                    $display("FAIL field: got idx=%0d data=%0h sgn=%0b last=%0b expected idx=%0d data=%0h sgn=%0b last=%0b",
                             bus.out_idx, bus.out_data, bus.out_signed, bus.out_last,
                             e.idx, e.data, e.sgn, e.last);
                end
            end
        end
    end

    // Present a word and wait (bounded) for the accepting edge; in_valid stays high
    task automatic accept_word(logic [89:0] w, output int cyc);
        logic r;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        cyc = 0;
        do begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            cyc++;
        end while (!r && cyc < 100);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        #1;
    endtask

    task automatic send_word(logic [89:0] w);
        int c;
        accept_word(w, c);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [89:0] w, w2;
        logic [7:0]  exp7;
        int          c;

        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_signed", bus.out_signed, 0);
        chk("rst_out_last", bus.out_last, 0);

        // Only y3 = 4'b1000
        w = put_field('0, 3, 6'b001000);
        for (int k = 0; k < 18; k++) push_exp(k, (k == 3) ? 8'hF8 : 8'h00);
        send_word(w);
        drain();

        // y1 = 5'b10000, y17 = 6'b111111
        w = put_field(put_field('0, 1, 6'b010000), 17, 6'b111111);
        for (int k = 0; k < 18; k++)
            push_exp(k, (k == 1) ? 8'h10 : ((k == 17) ? 8'hFF : 8'h00));
        send_word(w);
        drain();

        // Backpressure at idx 7 for 5 cycles
        w = {30'h2A5C3B1E, 30'h1234ABCD, 30'h3F0F00F5};
        push_model(w);
        bus.out_ready = 1'b0;
        send_word(w);
        repeat (7) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        exp7 = model_field(w, 7);
        repeat (5) begin
            @(negedge clk);
            chk("bp_idx", bus.out_idx, 7);
            chk("bp_data", bus.out_data, exp7);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back words with in_valid held
        w  = {30'h15555555, 30'h0F0F0F0F, 30'h33CC33CC};
        w2 = {30'h3C3C3C3C, 30'h2222DDDD, 30'h01234567};
        push_model(w);
        push_model(w2);
        accept_word(w, c);
        bus.in_word = w2;
        accept_word(w2, c);
        chk("b2b_accept_gap", c, 18);
        chk("b2b_queue_left", q.size(), 18);
        chk("b2b_no_bubble_valid", bus.out_valid, 1);
        chk("b2b_wrap_idx", bus.out_idx, 0);
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-word at idx 10
        w = {30'h2BADF00D, 30'h0C0FFEE5, 30'h1DEADBEE};
        push_model(w);
        send_word(w);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_idx", bus.out_idx, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_idx", bus.out_idx, 0);

        // All-ones word, restarting at idx 0 after the reset
        w = '1;
        for (int k = 0; k < 18; k++)
            push_exp(k, fsgn(k) ? 8'hFF :
                        (((k % 3) == 0) ? 8'h0F : (((k % 3) == 1) ? 8'h1F : 8'h3F)));
        send_word(w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
